// File: rtl/sample_strobe_gen_if.sv
// ---------------------------------------------------------------------------
// sample_strobe_gen_if
//
// Groups the request/data inputs and the strobe/status outputs of
// sample_strobe_gen into one bundle. Clock and reset stay plain ports on the
// modules that use this interface.
//
// Signals:
//   sample_req   level request to take one qualified sample
//   din_raw      raw asynchronous data bit
//   enable       one-cycle strobe towards the downstream sampling register
//   a            qualified data bit, held between strobes
//   busy         high while the generator is not idle
//   err_overrun  sticky: a request arrived while busy
//   err_timeout  sticky: qualification gave up without a stable value
//
// Modports:
//   master  the requesting side (drives sample_req/din_raw)
//   slave   the strobe generator itself
// ---------------------------------------------------------------------------
interface sample_strobe_gen_if;

  logic sample_req;
  logic din_raw;
  logic enable;
  logic a;
  logic busy;
  logic err_overrun;
  logic err_timeout;

  modport master (
    output sample_req,
    output din_raw,
    input  enable,
    input  a,
    input  busy,
    input  err_overrun,
    input  err_timeout
  );

  modport slave (
    input  sample_req,
    input  din_raw,
    output enable,
    output a,
    output busy,
    output err_overrun,
    output err_timeout
  );

endinterface

// File: rtl/sample_strobe_gen.sv
// ---------------------------------------------------------------------------
// sample_strobe_gen
//
// Upstream stage of the enable-gated sampling register. A raw asynchronous
// data bit is brought into the clk domain through a two-flop synchroniser,
// then, once a request is seen, it must hold the same value for
// STABLE_CYCLES consecutive synchronised samples before a single-cycle
// `enable` strobe is issued together with the qualified value on `a`.
// After every strobe the block idles for HOLDOFF_CYCLES cycles so that
// strobes are always spaced out. Requests that arrive while busy are
// dropped and flagged; a qualification that never settles is abandoned
// after TIMEOUT_CYCLES and flagged.
//
// Parameters:
//   STABLE_CYCLES   equal synchronised samples needed (1..255)
//   HOLDOFF_CYCLES  idle cycles forced after each strobe (0..255)
//   TIMEOUT_CYCLES  cycle limit for qualification (> STABLE_CYCLES, <= 255)
//
// Ports:
//   clk    single clock, all state on the rising edge
//   rst_n  asynchronous active-low reset, clears every flop
//   bus    sample_strobe_gen_if slave modport (request, data, strobe, flags)
// ---------------------------------------------------------------------------
module sample_strobe_gen #(
  parameter int STABLE_CYCLES  = 4,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  sample_strobe_gen_if.slave  bus
);

  // Counter compare values, pre-computed at 8 bits. When HOLDOFF_CYCLES is 0
  // HOLD_LAST wraps to 255, but HOLDOFF is never entered in that case.
  localparam logic [7:0] STABLE_LAST  = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST    = 8'(HOLDOFF_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam bit         SINGLE_SAMPLE = (STABLE_CYCLES == 1);
  localparam bit         NO_HOLDOFF    = (HOLDOFF_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    STROBE  = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       din_s1;
  logic       din_sync;

  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [7:0] tcnt;
  logic [7:0] tcnt_nxt;
  logic [7:0] hcnt;
  logic [7:0] hcnt_nxt;
  logic       cand;
  logic       cand_nxt;

  logic       qualified;
  logic       timeout_hit;
  logic       overrun_hit;
  logic       strobe_entry;

  logic       enable_q;
  logic       a_q;
  logic       err_overrun_q;
  logic       err_timeout_q;

  // Two-flop synchroniser for the asynchronous data input. Everything that
  // decides stability looks only at din_sync, never at din_raw, so the
  // qualification logic sees a clean signal two cycles late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_s1   <= 1'b0;
      din_sync <= 1'b0;
    end else begin
      din_s1   <= bus.din_raw;
      din_sync <= din_s1;
    end
  end

  // State register. Because reset is asynchronous the FSM drops back to
  // IDLE the moment rst_n falls, even in the middle of QUALIFY or STROBE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter and candidate registers. Their next values are worked out in
  // the next-state block below so that the FSM and its counters always move
  // together from a single decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 8'd0;
      tcnt <= 8'd0;
      hcnt <= 8'd0;
      cand <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tcnt <= tcnt_nxt;
      hcnt <= hcnt_nxt;
      cand <= cand_nxt;
    end
  end

  // Next-state and counter logic.
  //
  // IDLE takes the current synchronised value as the first candidate sample
  // (cnt=1) on a request. QUALIFY restarts the stability count whenever the
  // sample differs from the candidate, and declares success when the
  // STABLE_CYCLES-th equal sample arrives. The timeout counter runs in
  // parallel; if the limit is reached on the very cycle that qualifies, the
  // strobe still goes out and no timeout is recorded. STROBE lasts exactly
  // one cycle, then HOLDOFF counts hcnt from 0 up to HOLDOFF_CYCLES-1.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tcnt_nxt    = tcnt;
    hcnt_nxt    = hcnt;
    cand_nxt    = cand;
    qualified   = 1'b0;
    timeout_hit = 1'b0;

    case (state)
      IDLE: begin
        if (bus.sample_req) begin
          cand_nxt = din_sync;
          cnt_nxt  = 8'd1;
          tcnt_nxt = 8'd1;
          if (SINGLE_SAMPLE) begin
            state_nxt = STROBE;
          end else begin
            state_nxt = QUALIFY;
          end
        end
      end

      QUALIFY: begin
        tcnt_nxt = tcnt + 8'd1;
        if (din_sync != cand) begin
          cand_nxt = din_sync;
          cnt_nxt  = 8'd1;
        end else if (cnt == STABLE_LAST) begin
          qualified = 1'b1;
          state_nxt = STROBE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
        if (!qualified && (tcnt == TIMEOUT_LAST)) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end

      STROBE: begin
        if (NO_HOLDOFF) begin
          state_nxt = IDLE;
        end else begin
          hcnt_nxt  = 8'd0;
          state_nxt = HOLDOFF;
        end
      end

      HOLDOFF: begin
        if (hcnt == HOLD_LAST) begin
          state_nxt = IDLE;
        end else begin
          hcnt_nxt = hcnt + 8'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Event decodes feeding the output registers. A request is only ever
  // accepted in IDLE; in any other state it is dropped and counted as an
  // overrun. STROBE is never re-entered from itself, so "next state is
  // STROBE" marks exactly the entry edge.
  always_comb begin
    overrun_hit  = bus.sample_req && (state != IDLE);
    strobe_entry = (state_nxt == STROBE);
  end

  // Registered outputs. `enable` is high only for the single cycle spent in
  // STROBE, and `a` is loaded only on that same edge, so the downstream
  // register always sees a value that was stable when it was strobed and
  // keeps seeing it until the next strobe. The error flags are sticky and
  // only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q      <= 1'b0;
      a_q           <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      enable_q <= strobe_entry;
      if (strobe_entry) begin
        a_q <= cand_nxt;
      end
      if (overrun_hit) begin
        err_overrun_q <= 1'b1;
      end
      if (timeout_hit) begin
        err_timeout_q <= 1'b1;
      end
    end
  end

  // Drive the interface. busy is a pure decode of the registered state, so
  // it falls together with the asynchronous reset.
  assign bus.enable      = enable_q;
  assign bus.a           = a_q;
  assign bus.busy        = (state != IDLE);
  assign bus.err_overrun = err_overrun_q;
  assign bus.err_timeout = err_timeout_q;

`ifndef SYNTHESIS
  // The strobe is a single-cycle pulse; two back-to-back enables would mean
  // the FSM skipped its hold-off or re-entered STROBE.
  assert property (@(posedge clk) disable iff (!rst_n) enable_q |=> !enable_q);

  // The qualified data bit may only move on the edge that raises enable.
  assert property (@(posedge clk) disable iff (!rst_n) $changed(a_q) |-> enable_q);
`endif

endmodule

// File: tb/tb_sample_strobe_gen.sv
// ---------------------------------------------------------------------------
// tb_sample_strobe_gen
//
// Directed bench for sample_strobe_gen with the default parameters
// (STABLE_CYCLES=4, HOLDOFF_CYCLES=2, TIMEOUT_CYCLES=32). Each stimulus step
// that should produce a strobe pushes the expected `a` value and the clock
// count at which enable must be seen into a queue; an independent monitor
// pops an entry every time enable is high. Status flags are checked directly
// at chosen cycles.
// ---------------------------------------------------------------------------
module tb_sample_strobe_gen;

  typedef struct {
    logic a;
    int   cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   base;
  exp_t exp_q[$];
  exp_t mon_e;

  sample_strobe_gen_if bus ();

  sample_strobe_gen #(
    .STABLE_CYCLES (4),
    .HOLDOFF_CYCLES(2),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // 10 ns clock: rising edges at 5, 15, 25 ... and falling edges in between,
  // where all driving and checking happens.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running count of rising edges, used to time-stamp strobes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive the inputs for one cycle and return at the following falling edge.
  task automatic applyStimulus(input logic req, input logic din);
    bus.sample_req = req;
    bus.din_raw    = din;
    @(negedge clk);
  endtask

  // One comparison of an observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Queue one expected strobe: data value and the edge count at which it shows.
  task automatic expectStrobe(input logic a_val, input int at_cyc);
    exp_t e;
    e.a   = a_val;
    e.cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  // Check every output during reset.
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_enable"},      bus.enable,      32'd0);
    checkOutput({tag, "_a"},           bus.a,           32'd0);
    checkOutput({tag, "_busy"},        bus.busy,        32'd0);
    checkOutput({tag, "_err_overrun"}, bus.err_overrun, 32'd0);
    checkOutput({tag, "_err_timeout"}, bus.err_timeout, 32'd0);
  endtask

  // Monitor: every enable seen must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe: enable=1 a=%0b at cycle %0d, expected no strobe",
                 bus.a, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("strobe_cycle", cyc, mon_e.cyc);
        checkOutput("strobe_a", bus.a, mon_e.a);
      end
    end
  end

  initial begin
    cyc            = 0;
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.sample_req = 1'b0;
    bus.din_raw    = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    // Basic strobe: din=1 steady, single-cycle request at E0, strobe at E3.
    $display("[TB] basic strobe");
    repeat (3) applyStimulus(1'b0, 1'b1);
    base = cyc;
    expectStrobe(1'b1, base + 4);
    applyStimulus(1'b1, 1'b1);
    checkOutput("basic_busy_after_E0", bus.busy, 32'd1);
    repeat (5) applyStimulus(1'b0, 1'b1);
    checkOutput("basic_busy_after_E5", bus.busy, 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("basic_busy_after_E6", bus.busy, 32'd0);
    checkOutput("basic_err_overrun", bus.err_overrun, 32'd0);
    checkOutput("basic_err_timeout", bus.err_timeout, 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b1);

    // Timeout: din toggles every cycle so nothing ever qualifies; the abort
    // lands on E31 and `a` keeps the 1 from the previous strobe.
    $display("[TB] qualification timeout");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(i == 0, (i % 2) == 1);
      if (i + 1 == 31) begin
        checkOutput("timeout_flag_before", bus.err_timeout, 32'd0);
        checkOutput("timeout_busy_before", bus.busy, 32'd1);
      end
      if (i + 1 == 32) begin
        checkOutput("timeout_flag_set", bus.err_timeout, 32'd1);
        checkOutput("timeout_busy_idle", bus.busy, 32'd0);
      end
    end
    checkOutput("timeout_a_held", bus.a, 32'd1);
    checkOutput("timeout_no_overrun", bus.err_overrun, 32'd0);

    // Restarts: din_sync is 0 at E0/E1, 1 at E2/E3, 0 from E4 on. The last
    // restart is at E4, so the strobe comes on E7 with a=0.
    $display("[TB] restarts on toggling input");
    repeat (4) applyStimulus(1'b0, 1'b0);
    base = cyc;
    expectStrobe(1'b0, base + 8);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    repeat (12) applyStimulus(1'b0, 1'b0);
    checkOutput("toggle_busy_idle", bus.busy, 32'd0);
    checkOutput("toggle_timeout_sticky", bus.err_timeout, 32'd1);

    // Overrun: requests at E0 and E2, only one strobe; flag set on E2.
    $display("[TB] overrun");
    repeat (3) applyStimulus(1'b0, 1'b1);
    base = cyc;
    expectStrobe(1'b1, base + 4);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("overrun_before_E2", bus.err_overrun, 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("overrun_after_E2", bus.err_overrun, 32'd1);
    repeat (8) applyStimulus(1'b0, 1'b1);
    checkOutput("overrun_sticky", bus.err_overrun, 32'd1);

    // Reset pulse clears the sticky flags and `a` immediately.
    $display("[TB] reset pulse");
    rst_n = 1'b0;
    #1;
    checkAllZero("pulse");
    @(negedge clk);
    rst_n = 1'b1;

    // Held request: strobes on E3, E10, E17 (7 apart) and overrun from E1.
    $display("[TB] held request");
    repeat (3) applyStimulus(1'b0, 1'b1);
    base = cyc;
    expectStrobe(1'b1, base + 4);
    expectStrobe(1'b1, base + 11);
    expectStrobe(1'b1, base + 18);
    applyStimulus(1'b1, 1'b1);
    checkOutput("held_overrun_after_E0", bus.err_overrun, 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("held_overrun_after_E1", bus.err_overrun, 32'd1);
    repeat (18) applyStimulus(1'b1, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b1);
    checkOutput("held_busy_idle", bus.busy, 32'd0);

    // Reset in QUALIFY with cnt=2: that request never strobes; after
    // release a fresh request needs full qualification again.
    $display("[TB] reset mid-qualify");
    base = cyc;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("midq_busy_before", bus.busy, 32'd1);
    rst_n = 1'b0;
    #1;
    checkAllZero("midq");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b1);
    base = cyc;
    expectStrobe(1'b1, base + 4);
    applyStimulus(1'b1, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b1);
    checkOutput("midq_after_busy", bus.busy, 32'd0);

    // Every expected strobe must have been observed.
    checkOutput("pending_strobes", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
